// File: rtl/time_pkg.sv
// Shared types and helpers for the HH:MM:SS time-of-day counter.
//   bcd2         : packed two-digit BCD value, [7:4] tens, [3:0] units
//   *_MAX_DEF    : default last value of each field before rollover
//   state_t      : control FSM state encoding
//   to_bcd       : small decimal integer (0..99) to two-digit BCD
//   bcd_le       : true when both digits are legal and the value <= max
package time_pkg;

    typedef logic [7:0] bcd2;

    localparam int SEC_MAX_DEF  = 59;
    localparam int MIN_MAX_DEF  = 59;
    localparam int HOUR_MAX_DEF = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    function automatic bcd2 to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic bcd_le(input bcd2 a, input int max);
        int value;
        value = int'(a[7:4]) * 10 + int'(a[3:0]);
        return (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, 00..MAX, wrapping back to 00.
//   clk, rst_n : clock and asynchronous active-low reset (q -> 00)
//   inc        : advance by one
//   ld, ld_val : load ld_val (priority over inc); caller guarantees legality
//   q          : current value, BCD
//   carry      : combinational, inc while q == MAX (next stage advances)
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] q,
    output logic       carry
);

    localparam bcd2 MAX_BCD = to_bcd(MAX);

    assign carry = inc & (q == MAX_BCD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 8'h00;
        end else if (ld) begin
            q <= ld_val;
        end else if (inc) begin
            if (q == MAX_BCD) begin
                q <= 8'h00;
            end else if (q[3:0] == 4'd9) begin
                // units wrap, tens carry
                q <= {q[7:4] + 4'd1, 4'd0};
            end else begin
                q <= {q[7:4], q[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_counter_hms.sv
// 24-hour time-of-day counter (packed BCD HH:MM:SS) driven by a 1 Hz
// strobe that is synchronous to the 50 MHz system clock.
//   clk_50Mhz, rst_n          : system clock, asynchronous active-low reset
//   clk_1Hz                   : 1 Hz level; each rising edge is one second
//   en                        : 1 = count, 0 = hold (rises are discarded)
//   load, load_hh/mm/ss       : one-cycle time-set request with BCD values
//   hh_bcd, mm_bcd, ss_bcd    : current time, BCD
//   sec_tick                  : one-cycle pulse per second advance
//   day_tick                  : one-cycle pulse on rollover to 00:00:00
//   load_err                  : one-cycle pulse when a load is rejected
module time_counter_hms
    import time_pkg::*;
#(
    parameter int HOUR_MAX = HOUR_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int SEC_MAX  = SEC_MAX_DEF
) (
    input  logic       clk_50Mhz,
    input  logic       rst_n,
    input  logic       clk_1Hz,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       load_err
);

    logic   clk_1Hz_d;
    logic   rise;
    logic   advance;
    logic   load_ok;
    logic   do_load;
    logic   ss_carry;
    logic   mm_carry;
    logic   hh_carry;
    state_t state;
    state_t state_next;

    // Resetting the delay register to 1 means a strobe already high when
    // reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            clk_1Hz_d <= 1'b1;
        end else begin
            clk_1Hz_d <= clk_1Hz;
        end
    end

    assign rise    = clk_1Hz & ~clk_1Hz_d;
    // A load in the same cycle swallows the rise, valid or not.
    assign advance = rise & en & ~load;

    assign load_ok = bcd_le(load_ss, SEC_MAX) &
                     bcd_le(load_mm, MIN_MAX) &
                     bcd_le(load_hh, HOUR_MAX);
    assign do_load = load & load_ok;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk    (clk_50Mhz),
        .rst_n  (rst_n),
        .inc    (advance),
        .ld     (do_load),
        .ld_val (load_ss),
        .q      (ss_bcd),
        .carry  (ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk    (clk_50Mhz),
        .rst_n  (rst_n),
        .inc    (ss_carry),
        .ld     (do_load),
        .ld_val (load_mm),
        .q      (mm_bcd),
        .carry  (mm_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hh (
        .clk    (clk_50Mhz),
        .rst_n  (rst_n),
        .inc    (mm_carry),
        .ld     (do_load),
        .ld_val (load_hh),
        .q      (hh_bcd),
        .carry  (hh_carry)
    );

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= advance;
            day_tick <= hh_carry;
            load_err <= load & ~load_ok;
        end
    end

    // Control FSM: tracks mode for observability; it does not gate the
    // datapath above.
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_LOAD: state_next = load ? ST_LOAD : (en ? ST_RUN : ST_IDLE);
            default: state_next = load ? ST_LOAD : (en ? ST_RUN : ST_IDLE);
        endcase
    end

endmodule

// File: tb/tb_time_counter_hms.sv
module tb_time_counter_hms;

    logic       clk_50Mhz;
    logic       rst_n;
    logic       clk_1Hz;
    logic       en;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       sec_tick;
    logic       day_tick;
    logic       load_err;

    int tests;
    int fails;

    // pulse bookkeeping (monotonic; tests compare deltas)
    int   sec_seen;
    int   day_seen;
    int   err_seen;
    int   wide_seen;
    logic sec_prev;
    logic day_prev;
    logic err_prev;

    time_counter_hms dut (
        .clk_50Mhz (clk_50Mhz),
        .rst_n     (rst_n),
        .clk_1Hz   (clk_1Hz),
        .en        (en),
        .load      (load),
        .load_hh   (load_hh),
        .load_mm   (load_mm),
        .load_ss   (load_ss),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .sec_tick  (sec_tick),
        .day_tick  (day_tick),
        .load_err  (load_err)
    );

    initial clk_50Mhz = 1'b0;
    always #10 clk_50Mhz = ~clk_50Mhz;

    initial begin
        sec_seen = 0; day_seen = 0; err_seen = 0; wide_seen = 0;
        sec_prev = 1'b0; day_prev = 1'b0; err_prev = 1'b0;
    end

    always @(negedge clk_50Mhz) begin
        if (sec_tick) sec_seen++;
        if (day_tick) day_seen++;
        if (load_err) err_seen++;
        if ((sec_tick && sec_prev) || (day_tick && day_prev) || (load_err && err_prev))
            wide_seen++;
        sec_prev = sec_tick;
        day_prev = day_tick;
        err_prev = load_err;
    end

    // one 1 Hz period: high for 'high' cycles, then low for 3 cycles
    task automatic pulse_1hz(input int high);
        @(posedge clk_50Mhz); #1;
        clk_1Hz = 1'b1;
        repeat (high) @(posedge clk_50Mhz);
        #1;
        clk_1Hz = 1'b0;
        repeat (3) @(posedge clk_50Mhz);
        #1;
    endtask

    // drive a one-cycle load; returns #1 after the edge that samples it
    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(posedge clk_50Mhz); #1;
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        @(posedge clk_50Mhz); #1;
        load = 1'b0;
    endtask

    task automatic test_reset;
        int s0;
        rst_n = 1'b0; clk_1Hz = 1'b1; en = 1'b1; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        repeat (3) @(posedge clk_50Mhz);
        #1;
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd, sec_tick, day_tick, load_err} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h:%h:%h st=%b dt=%b le=%b want 00:00:00 0 0 0",
                     hh_bcd, mm_bcd, ss_bcd, sec_tick, day_tick, load_err);
        end
        s0 = sec_seen;
        rst_n = 1'b1;
        repeat (5) @(posedge clk_50Mhz);
        #1;
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin
            fails++;
            $display("FAIL reset_hold_high got %h:%h:%h want 00:00:00", hh_bcd, mm_bcd, ss_bcd);
        end
        tests++;
        if (sec_seen - s0 != 0) begin
            fails++;
            $display("FAIL reset_no_tick got %0d sec_tick want 0", sec_seen - s0);
        end
        clk_1Hz = 1'b0;
        repeat (2) @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic test_count;
        int s0, d0, w0;
        s0 = sec_seen; d0 = day_seen; w0 = wide_seen;
        for (int i = 0; i < 10; i++) pulse_1hz(3);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000010) begin
            fails++;
            $display("FAIL count_10 got %h:%h:%h want 00:00:10", hh_bcd, mm_bcd, ss_bcd);
        end
        tests++;
        if (sec_seen - s0 != 10) begin
            fails++;
            $display("FAIL count_sec_ticks got %0d want 10", sec_seen - s0);
        end
        tests++;
        if (wide_seen - w0 != 0 || day_seen - d0 != 0) begin
            fails++;
            $display("FAIL count_pulse_shape got wide=%0d day=%0d want 0 0",
                     wide_seen - w0, day_seen - d0);
        end
        // units 9 -> tens carry across a minute: 00:00:10 + 50 s = 00:01:00
        for (int i = 0; i < 50; i++) pulse_1hz(1);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000100) begin
            fails++;
            $display("FAIL count_minute got %h:%h:%h want 00:01:00", hh_bcd, mm_bcd, ss_bcd);
        end
    endtask

    task automatic test_rollover;
        int d0, s0;
        do_load(8'h23, 8'h59, 8'h58);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h235958) begin
            fails++;
            $display("FAIL roll_load got %h:%h:%h want 23:59:58", hh_bcd, mm_bcd, ss_bcd);
        end
        d0 = day_seen; s0 = sec_seen;
        pulse_1hz(2);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h235959 || day_seen - d0 != 0) begin
            fails++;
            $display("FAIL roll_first got %h:%h:%h day=%0d want 23:59:59 day=0",
                     hh_bcd, mm_bcd, ss_bcd, day_seen - d0);
        end
        pulse_1hz(2);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000 || day_seen - d0 != 1) begin
            fails++;
            $display("FAIL roll_second got %h:%h:%h day=%0d want 00:00:00 day=1",
                     hh_bcd, mm_bcd, ss_bcd, day_seen - d0);
        end
        tests++;
        if (sec_seen - s0 != 2) begin
            fails++;
            $display("FAIL roll_sec_ticks got %0d want 2", sec_seen - s0);
        end
    endtask

    task automatic test_bad_load;
        logic [7:0] bad_h [3];
        logic [7:0] bad_m [3];
        logic [7:0] bad_s [3];
        int e0;
        bad_h[0] = 8'h24; bad_m[0] = 8'h00; bad_s[0] = 8'h00;
        bad_h[1] = 8'h01; bad_m[1] = 8'h02; bad_s[1] = 8'h5A;
        bad_h[2] = 8'h01; bad_m[2] = 8'h60; bad_s[2] = 8'h00;
        do_load(8'h07, 8'h08, 8'h09);
        for (int i = 0; i < 3; i++) begin
            e0 = err_seen;
            do_load(bad_h[i], bad_m[i], bad_s[i]);
            tests++;
            if (load_err !== 1'b1 || {hh_bcd, mm_bcd, ss_bcd} !== 24'h070809) begin
                fails++;
                $display("FAIL bad_load_%0d got err=%b time=%h:%h:%h want err=1 07:08:09",
                         i, load_err, hh_bcd, mm_bcd, ss_bcd);
            end
            repeat (2) @(posedge clk_50Mhz);
            #1;
            tests++;
            if (err_seen - e0 != 1 || load_err !== 1'b0) begin
                fails++;
                $display("FAIL bad_load_pulse_%0d got %0d pulses err=%b want 1 err=0",
                         i, err_seen - e0, load_err);
            end
        end
        // boundary values that are legal must not raise load_err
        e0 = err_seen;
        do_load(8'h23, 8'h59, 8'h59);
        tests++;
        if (load_err !== 1'b0 || {hh_bcd, mm_bcd, ss_bcd} !== 24'h235959) begin
            fails++;
            $display("FAIL max_load got err=%b time=%h:%h:%h want err=0 23:59:59",
                     load_err, hh_bcd, mm_bcd, ss_bcd);
        end
    endtask

    task automatic test_load_vs_rise;
        int s0, d0;
        s0 = sec_seen; d0 = day_seen;
        // 23:59:59 loaded, so a leaked rise would also roll the day
        @(posedge clk_50Mhz); #1;
        load = 1'b1; clk_1Hz = 1'b1;
        load_hh = 8'h12; load_mm = 8'h34; load_ss = 8'h56;
        @(posedge clk_50Mhz); #1;
        load = 1'b0;
        repeat (2) @(posedge clk_50Mhz);
        #1;
        clk_1Hz = 1'b0;
        repeat (3) @(posedge clk_50Mhz);
        #1;
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123456 || sec_seen - s0 != 0 || day_seen - d0 != 0) begin
            fails++;
            $display("FAIL load_rise got %h:%h:%h st=%0d dt=%0d want 12:34:56 0 0",
                     hh_bcd, mm_bcd, ss_bcd, sec_seen - s0, day_seen - d0);
        end
        pulse_1hz(3);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123457 || sec_seen - s0 != 1) begin
            fails++;
            $display("FAIL load_rise_next got %h:%h:%h st=%0d want 12:34:57 1",
                     hh_bcd, mm_bcd, ss_bcd, sec_seen - s0);
        end
    endtask

    task automatic test_enable;
        int s0;
        s0 = sec_seen;
        @(posedge clk_50Mhz); #1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) pulse_1hz(2);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123457 || sec_seen - s0 != 0) begin
            fails++;
            $display("FAIL en_hold got %h:%h:%h st=%0d want 12:34:57 0",
                     hh_bcd, mm_bcd, ss_bcd, sec_seen - s0);
        end
        en = 1'b1;
        pulse_1hz(2);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123458 || sec_seen - s0 != 1) begin
            fails++;
            $display("FAIL en_resume got %h:%h:%h st=%0d want 12:34:58 1",
                     hh_bcd, mm_bcd, ss_bcd, sec_seen - s0);
        end
        // load is accepted while disabled
        en = 1'b0;
        do_load(8'h01, 8'h02, 8'h03);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010203) begin
            fails++;
            $display("FAIL en0_load got %h:%h:%h want 01:02:03", hh_bcd, mm_bcd, ss_bcd);
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset;
        pulse_1hz(1);
        pulse_1hz(1);
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010205) begin
            fails++;
            $display("FAIL pre_reset got %h:%h:%h want 01:02:05", hh_bcd, mm_bcd, ss_bcd);
        end
        @(posedge clk_50Mhz); #1;
        clk_1Hz = 1'b1;
        @(posedge clk_50Mhz); #3;
        rst_n = 1'b0;
        #2;
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd, sec_tick} !== 25'd0) begin
            fails++;
            $display("FAIL async_reset got %h:%h:%h st=%b want 00:00:00 0",
                     hh_bcd, mm_bcd, ss_bcd, sec_tick);
        end
        repeat (2) @(posedge clk_50Mhz);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_50Mhz);
        #1;
        tests++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin
            fails++;
            $display("FAIL post_reset got %h:%h:%h want 00:00:00", hh_bcd, mm_bcd, ss_bcd);
        end
        clk_1Hz = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_count;
        test_rollover;
        test_bad_load;
        test_load_vs_rise;
        test_enable;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
